hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller for a 5-stage RISC-V style core.
//   - Detects load-use hazards between EX (load) and ID (consumer) and
//     inserts exactly one bubble per pair.
//   - Issues IF/ID and ID/EX flushes on a branch/jump redirect from EX.
//   - Freezes the whole pipeline while data memory is busy or the core
//     is debug-halted.
//   - Debug FSM: RUN / HALT / STEP / MEM_WAIT.
//   - Performance counters for stall cycles, flush cycles and total cycles.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   inst_d_i, inst_ex_i   instructions held in IF/ID and ID/EX
//   RegWEn_ex_i           EX-stage register write enable
//   pc_sel_i              redirect resolved in EX
//   mem_busy_i            data memory/IO not ready
//   dbg_halt_i            debug halt request (level)
//   dbg_step_i            debug single-step request (pulse)
//   cnt_clr_i             synchronous counter clear
//   stall_*_o             hold PC / IF-ID / ID-EX / EX-MEM
//   flush_if_o, flush_id_o  load NOP into IF/ID / ID/EX
//   state_o               FSM state (RUN=0, HALT=1, STEP=2, MEM_WAIT=3)
//   *_cnt_o               performance counters, wrap modulo 2^CNT_W
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      inst_d_i,
  input  logic [31:0]      inst_ex_i,
  input  logic             RegWEn_ex_i,
  input  logic             pc_sel_i,
  input  logic             mem_busy_i,
  input  logic             dbg_halt_i,
  input  logic             dbg_step_i,
  input  logic             cnt_clr_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_ex_o,
  output logic             stall_mem_o,
  output logic             flush_if_o,
  output logic             flush_id_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    HALT     = 3'd1,
    STEP     = 3'd2,
    MEM_WAIT = 3'd3
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t           state_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, cycle_cnt_q;

  // ---------------------------------------------------------------------
  // Load-use detection
  // ---------------------------------------------------------------------
  logic [6:0] op_d;
  logic [4:0] rd_ex, rs1_d, rs2_d;
  logic       uses_rs1, uses_rs2, lu;

  always_comb begin
    op_d     = inst_d_i[6:0];
    rd_ex    = inst_ex_i[11:7];
    rs1_d    = inst_d_i[19:15];
    rs2_d    = inst_d_i[24:20];
    uses_rs1 = (op_d != OP_LUI) && (op_d != OP_AUIPC) && (op_d != OP_JAL);
    uses_rs2 = (op_d == OP_RTYPE) || (op_d == OP_STORE) || (op_d == OP_BRANCH);
    lu       = (inst_ex_i[6:0] == OP_LOAD) && RegWEn_ex_i && (rd_ex != 5'd0) &&
               ((uses_rs1 && (rd_ex == rs1_d)) || (uses_rs2 && (rd_ex == rs2_d)));
  end

  // ---------------------------------------------------------------------
  // Stall / flush priority: reset > freeze > redirect > load-use.
  // A redirect seen under freeze is not latched: EX is held, so pc_sel_i
  // is still asserted in the first unfrozen cycle and the flush goes out then.
  // ---------------------------------------------------------------------
  logic freeze;

  always_comb begin
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    stall_ex_o  = 1'b0;
    stall_mem_o = 1'b0;
    flush_if_o  = 1'b0;
    flush_id_o  = 1'b0;
    freeze      = !rst_i && (mem_busy_i || (state_q == HALT));
    if (rst_i) begin
      // everything stays deasserted
    end else if (freeze) begin
      stall_if_o  = 1'b1;
      stall_id_o  = 1'b1;
      stall_ex_o  = 1'b1;
      stall_mem_o = 1'b1;
    end else if (pc_sel_i) begin
      flush_if_o  = 1'b1;
      flush_id_o  = 1'b1;
    end else if (lu) begin
      stall_if_o  = 1'b1;
      stall_id_o  = 1'b1;
      flush_id_o  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Debug / memory-wait FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_busy_i)      state_q <= MEM_WAIT;
          else if (dbg_halt_i) state_q <= HALT;
        end
        MEM_WAIT: begin
          if (!mem_busy_i) state_q <= dbg_halt_i ? HALT : RUN;
        end
        HALT: begin
          if (dbg_step_i)       state_q <= STEP;
          else if (!dbg_halt_i) state_q <= RUN;
        end
        STEP: begin
          if (mem_busy_i)      state_q <= MEM_WAIT;
          else if (dbg_halt_i) state_q <= HALT;
          else                 state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Performance counters (clear wins over increment)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 1'b1;
      if (stall_if_o) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_if_o) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign cycle_cnt_o = cycle_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed self-checking bench for hazard_ctrl. Counters are built 4 bits
//   wide so wrap-around can be observed in a short run.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int unsigned CW = 4;

  // outs = {stall_if, stall_id, stall_ex, stall_mem, flush_if, flush_id}
  localparam logic [5:0] O_NONE   = 6'b000000;
  localparam logic [5:0] O_LU     = 6'b110001;
  localparam logic [5:0] O_FREEZE = 6'b111100;
  localparam logic [5:0] O_REDIR  = 6'b000011;

  localparam logic [31:0] LW_X5  = 32'h0000A283;
  localparam logic [31:0] LW_X0  = 32'h0000A003;
  localparam logic [31:0] ADD_X6 = 32'h00728333;
  localparam logic [31:0] LUI_X6 = 32'h00028337;
  localparam logic [31:0] SW_X5  = 32'h0050A023;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic          clk_i = 1'b0;
  logic          rst_i, RegWEn_ex_i, pc_sel_i, mem_busy_i;
  logic          dbg_halt_i, dbg_step_i, cnt_clr_i;
  logic [31:0]   inst_d_i, inst_ex_i;
  logic          stall_if_o, stall_id_o, stall_ex_o, stall_mem_o;
  logic          flush_if_o, flush_id_o;
  logic [2:0]    state_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o, cycle_cnt_o;
  logic [5:0]    outs;

  int checks = 0;
  int errors = 0;

  assign outs = {stall_if_o, stall_id_o, stall_ex_o, stall_mem_o, flush_if_o, flush_id_o};

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .inst_d_i(inst_d_i), .inst_ex_i(inst_ex_i),
    .RegWEn_ex_i(RegWEn_ex_i), .pc_sel_i(pc_sel_i), .mem_busy_i(mem_busy_i),
    .dbg_halt_i(dbg_halt_i), .dbg_step_i(dbg_step_i), .cnt_clr_i(cnt_clr_i),
    .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .stall_ex_o(stall_ex_o),
    .stall_mem_o(stall_mem_o), .flush_if_o(flush_if_o), .flush_id_o(flush_id_o),
    .state_o(state_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
    .cycle_cnt_o(cycle_cnt_o)
  );

  // advance past one rising edge; inputs are then changed and outputs sampled mid-cycle
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    RegWEn_ex_i = 1'b0; pc_sel_i = 1'b0; mem_busy_i = 1'b0;
    dbg_halt_i  = 1'b0; dbg_step_i = 1'b0; cnt_clr_i = 1'b0;
    inst_d_i = NOP; inst_ex_i = NOP;
  endtask

  task automatic clear_counters();
    cnt_clr_i = 1'b1;
    step();
    cnt_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_i = 1'b1; mem_busy_i = 1'b1; pc_sel_i = 1'b1;
    #1;
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL reset_outs: got %b expected %b", outs, O_NONE);
    end
    step();
    checks++;
    if (state_o !== 3'd0 || stall_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0 || cycle_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d cnts=%0d/%0d/%0d expected 0/0/0/0",
               state_o, stall_cnt_o, flush_cnt_o, cycle_cnt_o);
    end
    rst_i = 1'b0;
    idle();
  endtask

  task automatic test_load_use();
    clear_counters();
    inst_ex_i = LW_X5; RegWEn_ex_i = 1'b1; inst_d_i = ADD_X6;
    #1;
    checks++;
    if (outs !== O_LU) begin
      errors++; $display("FAIL load_use: got %b expected %b", outs, O_LU);
    end
    step();
    inst_ex_i = NOP;
    #1;
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL load_use_bubble_done: got %b expected %b", outs, O_NONE);
    end
    step();
    checks++;
    if (stall_cnt_o !== 4'd1 || cycle_cnt_o !== 4'd2 || flush_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL load_use_cnt: stall=%0d cycle=%0d flush=%0d expected 1/2/0",
               stall_cnt_o, cycle_cnt_o, flush_cnt_o);
    end
    idle();
  endtask

  task automatic test_no_hazard();
    RegWEn_ex_i = 1'b1; inst_ex_i = LW_X0; inst_d_i = ADD_X6;
    #1;
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL lw_x0: got %b expected %b", outs, O_NONE);
    end
    inst_ex_i = LW_X5; inst_d_i = LUI_X6;
    #1;
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL lui_rs1_field: got %b expected %b", outs, O_NONE);
    end
    inst_d_i = ADD_X6; RegWEn_ex_i = 1'b0;
    #1;
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL no_regwen: got %b expected %b", outs, O_NONE);
    end
    RegWEn_ex_i = 1'b1; inst_d_i = SW_X5;  // store reads x5 through rs2
    #1;
    checks++;
    if (outs !== O_LU) begin
      errors++; $display("FAIL store_rs2: got %b expected %b", outs, O_LU);
    end
    inst_ex_i = NOP;
    #1;
    checks++;
    if (outs !== O_NONE) begin
      errors++; $display("FAIL non_load_ex: got %b expected %b", outs, O_NONE);
    end
    idle();
  endtask

  task automatic test_redirect();
    clear_counters();
    inst_ex_i = LW_X5; RegWEn_ex_i = 1'b1; inst_d_i = ADD_X6; pc_sel_i = 1'b1;
    #1;
    checks++;
    if (outs !== O_REDIR) begin
      errors++; $display("FAIL redirect_over_lu: got %b expected %b", outs, O_REDIR);
    end
    step();
    idle();
    checks++;
    if (flush_cnt_o !== 4'd1 || stall_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL redirect_cnt: flush=%0d stall=%0d expected 1/0", flush_cnt_o, stall_cnt_o);
    end
  endtask

  task automatic test_mem_wait();
    clear_counters();
    pc_sel_i = 1'b1; mem_busy_i = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1;
      checks++;
      if (outs !== O_FREEZE || state_o !== ((i == 1) ? 3'd0 : 3'd3)) begin
        errors++;
        $display("FAIL mem_wait_c%0d: outs=%b state=%0d expected %b state %0d",
                 i, outs, state_o, O_FREEZE, (i == 1) ? 0 : 3);
      end
      step();
    end
    mem_busy_i = 1'b0;
    #1;
    checks++;
    if (outs !== O_REDIR || state_o !== 3'd3) begin
      errors++;
      $display("FAIL mem_release: outs=%b state=%0d expected %b state 3", outs, state_o, O_REDIR);
    end
    step();
    idle();
    checks++;
    if (stall_cnt_o !== 4'd3 || flush_cnt_o !== 4'd1 || state_o !== 3'd0) begin
      errors++;
      $display("FAIL mem_wait_cnt: stall=%0d flush=%0d state=%0d expected 3/1/0",
               stall_cnt_o, flush_cnt_o, state_o);
    end
  endtask

  task automatic test_debug();
    dbg_halt_i = 1'b1;
    step();
    checks++;
    if (state_o !== 3'd1 || outs !== O_FREEZE) begin
      errors++; $display("FAIL halt_entry: state=%0d outs=%b expected 1 %b", state_o, outs, O_FREEZE);
    end
    mem_busy_i = 1'b1;  // no effect while halted
    step();
    mem_busy_i = 1'b0;
    checks++;
    if (state_o !== 3'd1) begin
      errors++; $display("FAIL halt_ignores_busy: state=%0d expected 1", state_o);
    end
    dbg_step_i = 1'b1;
    step();
    dbg_step_i = 1'b0;
    #1;
    checks++;
    if (state_o !== 3'd2 || outs !== O_NONE) begin
      errors++; $display("FAIL step_cycle: state=%0d outs=%b expected 2 %b", state_o, outs, O_NONE);
    end
    step();
    checks++;
    if (state_o !== 3'd1) begin
      errors++; $display("FAIL step_return: state=%0d expected 1", state_o);
    end
    dbg_halt_i = 1'b0;
    step();
    checks++;
    if (state_o !== 3'd0 || outs !== O_NONE) begin
      errors++; $display("FAIL halt_exit: state=%0d outs=%b expected 0 %b", state_o, outs, O_NONE);
    end
  endtask

  task automatic test_counters();
    clear_counters();
    for (int i = 0; i < 17; i++) step();
    checks++;
    if (cycle_cnt_o !== 4'd1) begin
      errors++; $display("FAIL cycle_wrap: got %0d expected 1", cycle_cnt_o);
    end
    // clear coincident with a stall cycle: clear wins
    inst_ex_i = LW_X5; RegWEn_ex_i = 1'b1; inst_d_i = ADD_X6; cnt_clr_i = 1'b1;
    step();
    idle();
    checks++;
    if (stall_cnt_o !== 4'd0 || cycle_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL clear_wins: stall=%0d cycle=%0d expected 0/0", stall_cnt_o, cycle_cnt_o);
    end
  endtask

  task automatic test_reset_mid_wait();
    clear_counters();
    mem_busy_i = 1'b1;
    step();
    step();
    rst_i = 1'b1;
    #1;
    checks++;
    if (outs !== O_NONE || state_o !== 3'd3 || stall_cnt_o !== 4'd2) begin
      errors++;
      $display("FAIL reset_mid_outs: outs=%b state=%0d stall=%0d expected %b 3 2",
               outs, state_o, stall_cnt_o, O_NONE);
    end
    step();
    checks++;
    if (state_o !== 3'd0 || stall_cnt_o !== 4'd0 || cycle_cnt_o !== 4'd0 || flush_cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid_state: state=%0d cnts=%0d/%0d/%0d expected 0/0/0/0",
               state_o, stall_cnt_o, flush_cnt_o, cycle_cnt_o);
    end
    rst_i = 1'b0;
    idle();
    step();
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    step();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_redirect();
    test_mem_wait();
    test_debug();
    test_counters();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
